// File: rtl/cpu_controller_pkg.sv
// rtl/cpu_controller_pkg.sv - shared types and constants for the CPU control FSM
package cpu_ctrl_pkg;

    localparam int PSRL_DEF = 5;
    localparam int OPW_DEF  = 4;

    typedef enum logic [3:0] {
        S_FETCH0, S_FETCH1, S_DECODE, S_EX_R, S_EX_I, S_WB_ALU, S_WB_IMM, S_WB_MOV,
        S_LOAD0, S_LOAD1, S_STORE, S_BRANCH, S_JUMP, S_ILLEGAL, S_HALT
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_MULI  = 4'b1001;
    localparam logic [3:0] OP_SUBI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;

    localparam logic [3:0] EXT_MOV   = 4'b1101;
    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STOR  = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;

    localparam logic [1:0] WD_IMM = 2'b00;
    localparam logic [1:0] WD_RSRC = 2'b01;
    localparam logic [1:0] WD_MEM = 2'b10;
    localparam logic [1:0] WD_ALU = 2'b11;

    localparam logic [1:0] ALUA_RSRC = 2'b00;
    localparam logic [1:0] ALUA_PC   = 2'b01;
    localparam logic [1:0] ALUA_IMM  = 2'b10;

    localparam logic [1:0] ALUB_RDEST = 2'b00;
    localparam logic [1:0] ALUB_IMM   = 2'b01;
    localparam logic [1:0] ALUB_ONE   = 2'b10;

    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_GE = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;

    typedef struct packed {
        logic       pc_s;
        logic       mem_s;
        logic [1:0] wd_s;
        logic [1:0] alua_s;
        logic [1:0] alub_s;
        logic       instr_en;
        logic       alu_out_en;
        logic       mem_reg_en;
        logic       pc_en;
        logic       psr_en;
        logic       se_sign;
        logic       reg_wr;
        logic       mem_we;
        logic       trap;
    } ctrl_t;

    // Arithmetic immediates are signed; logical immediates are zero-extended.
    function automatic logic imm_is_signed(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_MULI);
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// rtl/cpu_controller_if.sv - controller <-> datapath signal bundle
interface cpu_controller_if
    import cpu_ctrl_pkg::*;
#(
    parameter int PSRL = PSRL_DEF,
    parameter int OPW  = OPW_DEF
);
    logic [OPW-1:0]  OP_CODE;
    logic [OPW-1:0]  OP_EXT;
    logic [OPW-1:0]  Rdest_addr;
    logic [PSRL-1:0] PSR_OUT;
    logic            mem_rdy;
    logic            PC_S;
    logic            MEM_S;
    logic [1:0]      WD_S;
    logic [1:0]      ALUA_S;
    logic [1:0]      ALUB_S;
    logic            INSTR_EN;
    logic            ALU_OUT_EN;
    logic            MEM_REG_EN;
    logic            PC_EN;
    logic            PSR_EN;
    logic            SE_SIGN;
    logic            REG_WR;
    logic            MEM_WE;
    logic            trap;

    modport master (
        input  OP_CODE, OP_EXT, Rdest_addr, PSR_OUT, mem_rdy,
        output PC_S, MEM_S, WD_S, ALUA_S, ALUB_S, INSTR_EN, ALU_OUT_EN,
               MEM_REG_EN, PC_EN, PSR_EN, SE_SIGN, REG_WR, MEM_WE, trap
    );

    modport slave (
        output OP_CODE, OP_EXT, Rdest_addr, PSR_OUT, mem_rdy,
        input  PC_S, MEM_S, WD_S, ALUA_S, ALUB_S, INSTR_EN, ALU_OUT_EN,
               MEM_REG_EN, PC_EN, PSR_EN, SE_SIGN, REG_WR, MEM_WE, trap
    );
endinterface

// File: rtl/cpu_controller_cond_eval.sv
// rtl/cpu_controller_cond_eval.sv - branch/jump condition evaluation on PSR flags
module cond_eval
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0]          cond,
    input  logic [PSRL_DEF-1:0] psr,
    output logic                taken
);
    logic unused_low_flag;
    assign unused_low_flag = psr[PSR_L];

    // Decode the condition field against the registered flags.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = psr[PSR_Z];
            COND_NE: taken = !psr[PSR_Z];
            COND_CS: taken = psr[PSR_C];
            COND_CC: taken = !psr[PSR_C];
            COND_GT: taken = psr[PSR_N];
            COND_LE: taken = !psr[PSR_N];
            COND_FS: taken = psr[PSR_F];
            COND_FC: taken = !psr[PSR_F];
            COND_LT: taken = !psr[PSR_N] && !psr[PSR_Z];
            COND_GE: taken = psr[PSR_N] || psr[PSR_Z];
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - multicycle control FSM; optional ILLEGAL_TRAP_EN halts on illegal opcodes
module cpu_controller
    import cpu_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    cpu_controller_if.master bus
);
    state_t state, state_nx;
    ctrl_t  base_q, base_nx;
    ctrl_t  rdy_q, rdy_nx;
    ctrl_t  ctrl_out;
    logic   taken;

    cond_eval u_cond_eval (
        .cond  (bus.Rdest_addr),
        .psr   (bus.PSR_OUT),
        .taken (taken)
    );

    // Next state, then the registered controls for that state; rdy_nx holds
    // the controls that only fire in the cycle memory reports ready.
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH0: state_nx = S_FETCH1;
            S_FETCH1: state_nx = bus.mem_rdy ? S_DECODE : S_FETCH1;
            S_DECODE: begin
                case (bus.OP_CODE)
                    OP_RTYPE: state_nx = (bus.OP_EXT == EXT_MOV) ? S_WB_MOV : S_EX_R;
                    OP_ADDI, OP_SUBI, OP_MULI, OP_ANDI, OP_ORI: state_nx = S_EX_I;
                    OP_MOVI:  state_nx = S_WB_IMM;
                    OP_BCOND: state_nx = S_BRANCH;
                    OP_MEM: begin
                        case (bus.OP_EXT)
                            EXT_LOAD:  state_nx = S_LOAD0;
                            EXT_STOR:  state_nx = S_STORE;
                            EXT_JCOND: state_nx = S_JUMP;
                            default:   state_nx = S_ILLEGAL;
                        endcase
                    end
                    default:  state_nx = S_ILLEGAL;
                endcase
            end
            S_EX_R, S_EX_I: state_nx = S_WB_ALU;
            S_LOAD0:  state_nx = S_LOAD1;
            S_LOAD1:  state_nx = bus.mem_rdy ? S_FETCH0 : S_LOAD1;
`ifdef ILLEGAL_TRAP_EN
            S_ILLEGAL: state_nx = S_HALT;
            S_HALT:    state_nx = S_HALT;
`else
            S_ILLEGAL: state_nx = S_FETCH0;
`endif
            default:  state_nx = S_FETCH0;
        endcase

        base_nx = '0;
        rdy_nx  = '0;
        case (state_nx)
            S_FETCH0: base_nx.mem_s = 1'b1;
            S_FETCH1: begin
                base_nx.mem_s    = 1'b1;
                rdy_nx.instr_en  = 1'b1;
                rdy_nx.pc_en     = 1'b1;
                rdy_nx.pc_s      = 1'b1;
                rdy_nx.alua_s    = ALUA_PC;
                rdy_nx.alub_s    = ALUB_ONE;
            end
            S_EX_R: begin
                base_nx.alua_s     = ALUA_RSRC;
                base_nx.alub_s     = ALUB_RDEST;
                base_nx.alu_out_en = 1'b1;
                base_nx.psr_en     = 1'b1;
            end
            S_EX_I: begin
                base_nx.alua_s     = ALUA_IMM;
                base_nx.alub_s     = ALUB_RDEST;
                base_nx.alu_out_en = 1'b1;
                base_nx.psr_en     = 1'b1;
                base_nx.se_sign    = imm_is_signed(bus.OP_CODE);
            end
            S_WB_ALU: begin
                base_nx.wd_s   = WD_ALU;
                base_nx.reg_wr = 1'b1;
            end
            S_WB_IMM: begin
                base_nx.wd_s   = WD_IMM;
                base_nx.reg_wr = 1'b1;
            end
            S_WB_MOV: begin
                base_nx.wd_s   = WD_RSRC;
                base_nx.reg_wr = 1'b1;
            end
            S_LOAD1: begin
                rdy_nx.mem_reg_en = 1'b1;
                rdy_nx.wd_s       = WD_MEM;
                rdy_nx.reg_wr     = 1'b1;
            end
            S_STORE: base_nx.mem_we = 1'b1;
            S_BRANCH: begin
                if (taken) begin
                    base_nx.pc_en   = 1'b1;
                    base_nx.pc_s    = 1'b1;
                    base_nx.alua_s  = ALUA_PC;
                    base_nx.alub_s  = ALUB_IMM;
                    base_nx.se_sign = 1'b1;
                end
            end
            S_JUMP: base_nx.pc_en = taken;
`ifdef ILLEGAL_TRAP_EN
            S_HALT: base_nx.trap = 1'b1;
`endif
            default: base_nx = '0;
        endcase
    end

    // State and registered controls; reset drops any pending strobe immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_FETCH0;
            base_q <= '0;
            rdy_q  <= '0;
        end else begin
            state  <= state_nx;
            base_q <= base_nx;
            rdy_q  <= rdy_nx;
        end
    end

    assign ctrl_out = base_q | (bus.mem_rdy ? rdy_q : '0);

    assign bus.PC_S       = ctrl_out.pc_s;
    assign bus.MEM_S      = ctrl_out.mem_s;
    assign bus.WD_S       = ctrl_out.wd_s;
    assign bus.ALUA_S     = ctrl_out.alua_s;
    assign bus.ALUB_S     = ctrl_out.alub_s;
    assign bus.INSTR_EN   = ctrl_out.instr_en;
    assign bus.ALU_OUT_EN = ctrl_out.alu_out_en;
    assign bus.MEM_REG_EN = ctrl_out.mem_reg_en;
    assign bus.PC_EN      = ctrl_out.pc_en;
    assign bus.PSR_EN     = ctrl_out.psr_en;
    assign bus.SE_SIGN    = ctrl_out.se_sign;
    assign bus.REG_WR     = ctrl_out.reg_wr;
    assign bus.MEM_WE     = ctrl_out.mem_we;
`ifdef ILLEGAL_TRAP_EN
    assign bus.trap       = ctrl_out.trap;
`else
    logic unused_trap;
    assign unused_trap    = ctrl_out.trap;
    assign bus.trap       = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - scoreboard bench for cpu_controller
module tb_cpu_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    cpu_controller_if bus ();

    cpu_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] ev(input logic pc_s, input logic mem_s, input logic [1:0] wd,
                                       input logic [1:0] alua, input logic [1:0] alub,
                                       input logic ie, input logic aoe, input logic mre,
                                       input logic pce, input logic psre, input logic se,
                                       input logic rw, input logic we, input logic tr);
        return {pc_s, mem_s, wd, alua, alub, ie, aoe, mre, pce, psre, se, rw, we, tr};
    endfunction

    localparam logic [16:0] E_ZERO  = 17'h0;
    localparam logic [16:0] E_F0    = ev(0,1,2'b00,2'b00,2'b00,0,0,0,0,0,0,0,0,0);
    localparam logic [16:0] E_F1R   = ev(1,1,2'b00,2'b01,2'b10,1,0,0,1,0,0,0,0,0);
    localparam logic [16:0] E_EXR   = ev(0,0,2'b00,2'b00,2'b00,0,1,0,0,1,0,0,0,0);
    localparam logic [16:0] E_EXI_S = ev(0,0,2'b00,2'b10,2'b00,0,1,0,0,1,1,0,0,0);
    localparam logic [16:0] E_EXI_U = ev(0,0,2'b00,2'b10,2'b00,0,1,0,0,1,0,0,0,0);
    localparam logic [16:0] E_WBALU = ev(0,0,2'b11,2'b00,2'b00,0,0,0,0,0,0,1,0,0);
    localparam logic [16:0] E_WBIMM = ev(0,0,2'b00,2'b00,2'b00,0,0,0,0,0,0,1,0,0);
    localparam logic [16:0] E_WBMOV = ev(0,0,2'b01,2'b00,2'b00,0,0,0,0,0,0,1,0,0);
    localparam logic [16:0] E_LD    = ev(0,0,2'b10,2'b00,2'b00,0,0,1,0,0,0,1,0,0);
    localparam logic [16:0] E_ST    = ev(0,0,2'b00,2'b00,2'b00,0,0,0,0,0,0,0,1,0);
    localparam logic [16:0] E_BRT   = ev(1,0,2'b00,2'b01,2'b01,0,0,0,1,0,1,0,0,0);
    localparam logic [16:0] E_JT    = ev(0,0,2'b00,2'b00,2'b00,0,0,0,1,0,0,0,0,0);
    localparam logic [16:0] E_TRAP  = ev(0,0,2'b00,2'b00,2'b00,0,0,0,0,0,0,0,0,1);

    typedef struct {
        logic [16:0] v;
        string       nm;
    } exp_t;
    exp_t sb_q[$];

    logic [16:0] got;
    assign got = {bus.PC_S, bus.MEM_S, bus.WD_S, bus.ALUA_S, bus.ALUB_S, bus.INSTR_EN,
                  bus.ALU_OUT_EN, bus.MEM_REG_EN, bus.PC_EN, bus.PSR_EN, bus.SE_SIGN,
                  bus.REG_WR, bus.MEM_WE, bus.trap};

    // Monitor: compare the DUT outputs against each queued expectation mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (got !== e.v) begin
                    failures++;
                    $display("FAIL %s got=%05h exp=%05h", e.nm, got, e.v);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic rdy, input logic [16:0] e, input string nm);
        @(posedge clk);
        #1;
        reset = rst;
        bus.mem_rdy = rdy;
        sb_q.push_back('{v: e, nm: nm});
    endtask

    task automatic fetch(input logic [15:0] instr, input string nm);
        bus.OP_CODE    = instr[15:12];
        bus.Rdest_addr = instr[11:8];
        bus.OP_EXT     = instr[7:4];
        step(1, 1, E_F1R, {nm, "_f1"});
        step(1, 1, E_ZERO, {nm, "_dec"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_rdy = 1'b0;
        bus.OP_CODE = '0;
        bus.OP_EXT = '0;
        bus.Rdest_addr = '0;
        bus.PSR_OUT = '0;

        step(0, 0, E_ZERO, "rst0");
        step(0, 1, E_ZERO, "rst1");
        step(1, 0, E_ZERO, "rel_f0");

        fetch(16'h0152, "add");
        step(1, 1, E_EXR,   "add_exr");
        step(1, 1, E_WBALU, "add_wb");
        step(1, 1, E_F0,    "add_f0");

        bus.OP_CODE = 4'h4; bus.Rdest_addr = 4'h1; bus.OP_EXT = 4'h0;
        step(1, 0, E_F0,    "ld_f1wait");
        fetch(16'h4102, "ld");
        step(1, 1, E_ZERO,  "ld_l0");
        step(1, 0, E_ZERO,  "ld_l1w1");
        step(1, 0, E_ZERO,  "ld_l1w2");
        step(1, 0, E_ZERO,  "ld_l1w3");
        step(1, 1, E_LD,    "ld_l1rdy");
        step(1, 0, E_F0,    "ld_f0");

        fetch(16'h4245, "st");
        step(1, 0, E_ST,    "st_we");
        step(1, 0, E_F0,    "st_f0");

        fetch(16'h5105, "addi");
        step(1, 1, E_EXI_S, "addi_ex");
        step(1, 1, E_WBALU, "addi_wb");
        step(1, 1, E_F0,    "addi_f0");

        fetch(16'h1105, "andi");
        step(1, 1, E_EXI_U, "andi_ex");
        step(1, 1, E_WBALU, "andi_wb");
        step(1, 1, E_F0,    "andi_f0");

        fetch(16'hD1FF, "movi");
        step(1, 1, E_WBIMM, "movi_wb");
        step(1, 1, E_F0,    "movi_f0");

        fetch(16'h01D2, "mov");
        step(1, 1, E_WBMOV, "mov_wb");
        step(1, 1, E_F0,    "mov_f0");

        bus.PSR_OUT = 5'b01000;
        fetch(16'hC005, "beq_t");
        step(1, 1, E_BRT,   "beq_t_br");
        step(1, 1, E_F0,    "beq_t_f0");

        bus.PSR_OUT = 5'b00000;
        fetch(16'hC005, "beq_f");
        step(1, 1, E_ZERO,  "beq_f_br");
        step(1, 1, E_F0,    "beq_f_f0");

        fetch(16'hCC05, "blt_t");
        step(1, 1, E_BRT,   "blt_t_br");
        step(1, 1, E_F0,    "blt_t_f0");

        bus.PSR_OUT = 5'b10000;
        fetch(16'hCC05, "blt_f");
        step(1, 1, E_ZERO,  "blt_f_br");
        step(1, 1, E_F0,    "blt_f_f0");

        fetch(16'h4EC3, "juc");
        step(1, 1, E_JT,    "juc_j");
        step(1, 1, E_F0,    "juc_f0");

        fetch(16'h4FC3, "jnv");
        step(1, 1, E_ZERO,  "jnv_j");
        step(1, 1, E_F0,    "jnv_f0");

        fetch(16'h0152, "rst_add");
        step(1, 1, E_EXR,   "rst_exr");
        step(0, 1, E_ZERO,  "rst_in_wb");
        step(0, 1, E_ZERO,  "rst_hold");
        step(1, 0, E_ZERO,  "rst_rel_f0");
        step(1, 0, E_F0,    "rst_rel_f1");

        fetch(16'h3000, "ill");
        step(1, 1, E_ZERO,  "ill_state");
`ifdef ILLEGAL_TRAP_EN
        step(1, 1, E_TRAP,  "ill_halt0");
        step(1, 1, E_TRAP,  "ill_halt1");
        step(1, 1, E_TRAP,  "ill_halt2");
        step(0, 1, E_ZERO,  "ill_rst");
        step(1, 1, E_ZERO,  "ill_rel_f0");
`else
        step(1, 1, E_F0,    "ill_nop_f0");
`endif
        fetch(16'h0152, "post");
        step(1, 1, E_EXR,   "post_exr");
        step(1, 1, E_WBALU, "post_wb");
        step(1, 1, E_F0,    "post_f0");

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
